tl_peri_slave: RTL and testbench

TL_PERI_SLAVE -- requirements
Module: tl_peri_slave

---
 rtl/tl_peri_slave.sv | 198 +++++++++++++++++++
 tb/tb_tl_peri_slave.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_peri_slave.sv
// TileLink-UL peripheral responder backed by a small word-addressed flop store.
// One request is accepted at a time. The response appears WAIT_CYCLES cycles
// after the accept cycle and is held until the crossbar takes it.
//
// state | meaning
// IDLE  | a_ready high, waiting for a Channel A request
// WAIT  | request done, burning programmable wait states before responding
// RESP  | d_valid high, D fields frozen until d_ready
module tl_peri_slave #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int                    SIZE_WIDTH   = 3,
  parameter int                    SRC_WIDTH    = 2,
  parameter int                    SINK_WIDTH   = 1,
  parameter int                    OPCODE_WIDTH = 3,
  parameter int                    PARAM_WIDTH  = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h1000_0000,
  parameter int                    DEPTH        = 16,
  parameter int                    WAIT_CYCLES  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [OPCODE_WIDTH-1:0] a_opcode,
  input  logic [PARAM_WIDTH-1:0]  a_param,
  input  logic [SIZE_WIDTH-1:0]   a_size,
  input  logic [SRC_WIDTH-1:0]    a_source,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [MASK_WIDTH-1:0]   a_mask,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [OPCODE_WIDTH-1:0] d_opcode,
  output logic [PARAM_WIDTH-1:0]  d_param,
  output logic [SIZE_WIDTH-1:0]   d_size,
  output logic [SRC_WIDTH-1:0]    d_source,
  output logic [SINK_WIDTH-1:0]   d_sink,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic                    d_error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PART = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_GET      = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ACK      = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_ACK_DATA = OPCODE_WIDTH'(1);

  // Window bounds are compared one bit wider than the address so the top of
  // the window cannot wrap past zero.
  localparam logic [ADDR_WIDTH:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] LIMIT_EXT = BASE_EXT + (ADDR_WIDTH+1)'(4 * DEPTH);

  // Counter preload: one less than the wait count since the WAIT state itself
  // consumes the final cycle when the counter reads zero.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q;
  logic [3:0]              wait_cnt_q;
  logic                    a_ready_q;
  logic                    d_valid_q;
  logic [OPCODE_WIDTH-1:0] d_opcode_q;
  logic [SIZE_WIDTH-1:0]   d_size_q;
  logic [SRC_WIDTH-1:0]    d_source_q;
  logic [DATA_WIDTH-1:0]   d_data_q;
  logic                    d_error_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    accept;
  logic                    is_get;
  logic                    is_put;
  logic                    align_ok;
  logic                    range_ok;
  logic                    req_err;
  logic                    wr_en;
  logic [ADDR_WIDTH:0]     addr_ext;
  logic [IDX_W-1:0]        idx;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   wr_word_d;
  logic                    unused_param;

  // a_param carries no meaning for this responder.
  assign unused_param = ^a_param;

  assign accept   = a_valid && a_ready_q;
  assign is_get   = (a_opcode == OP_GET);
  assign is_put   = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART);
  assign addr_ext = {1'b0, a_address};
  assign range_ok = (addr_ext >= BASE_EXT) && (addr_ext < LIMIT_EXT);
  assign idx      = IDX_W'((a_address - BASE_ADDR) >> 2);
  assign rd_word  = mem_q[idx];

  // Natural alignment check; sizes above a word are never legal here.
  always_comb begin
    align_ok = 1'b0;
    case (a_size)
      SIZE_WIDTH'(0): align_ok = 1'b1;
      SIZE_WIDTH'(1): align_ok = ~a_address[0];
      SIZE_WIDTH'(2): align_ok = (a_address[1:0] == 2'b00);
      default:        align_ok = 1'b0;
    endcase
  end

  assign req_err = !(is_get || is_put) || !align_ok || !range_ok;
  assign wr_en   = accept && is_put && !req_err;

  // Byte-merge the incoming data into the addressed word under a_mask.
  always_comb begin
    wr_word_d = rd_word;
    for (int b = 0; b < MASK_WIDTH; b++) begin
      if (a_mask[b]) wr_word_d[8*b +: 8] = a_data[8*b +: 8];
    end
  end

  // Storage update happens in the accept cycle so the next request sees it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[idx] <= wr_word_d;
    end
  end

  // Request/response sequencer with all handshake and D outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
      a_ready_q  <= 1'b1;
      d_valid_q  <= 1'b0;
      d_opcode_q <= '0;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_data_q   <= '0;
      d_error_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_ready_q  <= 1'b0;
            d_opcode_q <= is_get ? OP_ACK_DATA : OP_ACK;
            d_size_q   <= a_size;
            d_source_q <= a_source;
            d_error_q  <= req_err;
            d_data_q   <= (is_get && !req_err) ? rd_word : '0;
            if (WAIT_CYCLES > 0) begin
              state_q    <= WAIT;
              wait_cnt_q <= WAIT_LOAD;
            end else begin
              state_q   <= RESP;
              d_valid_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (wait_cnt_q == 4'd0) begin
            state_q   <= RESP;
            d_valid_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (d_ready) begin
            state_q   <= IDLE;
            d_valid_q <= 1'b0;
            a_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          d_valid_q <= 1'b0;
          a_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign a_ready  = a_ready_q;
  assign d_valid  = d_valid_q;
  assign d_opcode = d_opcode_q;
  assign d_param  = '0;
  assign d_size   = d_size_q;
  assign d_source = d_source_q;
  assign d_sink   = '0;
  assign d_data   = d_data_q;
  assign d_error  = d_error_q;

endmodule

// File: tb/tb_tl_peri_slave.sv
// Directed bench for tl_peri_slave: one instance with no wait states and one
// with three, sharing the Channel A payload but with separate handshakes.
module tb_tl_peri_slave;

  logic        clk = 1'b0;
  logic        rst0_n, rst3_n;
  logic        a_valid0, a_valid3, a_ready0, a_ready3;
  logic [2:0]  a_opcode, a_param, a_size;
  logic [1:0]  a_source;
  logic [31:0] a_address, a_data;
  logic [3:0]  a_mask;

  logic        d_valid0, d_ready0, d_sink0, d_error0;
  logic [2:0]  d_opcode0, d_param0, d_size0;
  logic [1:0]  d_source0;
  logic [31:0] d_data0;
  logic        d_valid3, d_ready3, d_sink3, d_error3;
  logic [2:0]  d_opcode3, d_param3, d_size3;
  logic [1:0]  d_source3;
  logic [31:0] d_data3;

  int          n_checks = 0;
  int          n_errors = 0;
  int          r_lat, busy_ready, cnt;
  logic [31:0] r_op, r_param, r_size, r_src, r_sink, r_data, r_err;

  always #5 clk = ~clk;

  tl_peri_slave #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst0_n),
    .a_valid(a_valid0), .a_ready(a_ready0), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid0), .d_ready(d_ready0), .d_opcode(d_opcode0), .d_param(d_param0),
    .d_size(d_size0), .d_source(d_source0), .d_sink(d_sink0), .d_data(d_data0),
    .d_error(d_error0)
  );

  tl_peri_slave #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(rst3_n),
    .a_valid(a_valid3), .a_ready(a_ready3), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid3), .d_ready(d_ready3), .d_opcode(d_opcode3), .d_param(d_param3),
    .d_size(d_size3), .d_source(d_source3), .d_sink(d_sink3), .d_data(d_data3),
    .d_error(d_error3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic dv(input bit w3);
    return w3 ? d_valid3 : d_valid0;
  endfunction

  function automatic logic ar(input bit w3);
    return w3 ? a_ready3 : a_ready0;
  endfunction

  task automatic capture(input bit w3);
    r_op    = 32'(w3 ? d_opcode3 : d_opcode0);
    r_param = 32'(w3 ? d_param3  : d_param0);
    r_size  = 32'(w3 ? d_size3   : d_size0);
    r_src   = 32'(w3 ? d_source3 : d_source0);
    r_sink  = 32'(w3 ? d_sink3   : d_sink0);
    r_data  = w3 ? d_data3 : d_data0;
    r_err   = 32'(w3 ? d_error3  : d_error0);
  endtask

  task automatic send(input bit w3, input logic [2:0] op, input logic [2:0] sz,
                      input logic [1:0] src, input logic [31:0] addr,
                      input logic [3:0] msk, input logic [31:0] dat);
    @(negedge clk);
    a_opcode = op; a_size = sz; a_source = src; a_address = addr;
    a_mask = msk; a_data = dat; a_param = 3'd5;
    chk("a_ready_idle", 32'(ar(w3)), 32'd1);
    if (w3) a_valid3 = 1'b1; else a_valid0 = 1'b1;
    @(posedge clk); #1;
    a_valid0 = 1'b0; a_valid3 = 1'b0;
  endtask

  task automatic wait_d(input bit w3);
    r_lat = 0; busy_ready = 0;
    @(negedge clk);
    while (dv(w3) !== 1'b1 && r_lat < 40) begin
      if (ar(w3) !== 1'b0) busy_ready++;
      r_lat++;
      @(negedge clk);
    end
    if (ar(w3) !== 1'b0) busy_ready++;
    capture(w3);
  endtask

  task automatic finish_d(input bit w3);
    if (w3) d_ready3 = 1'b1; else d_ready0 = 1'b1;
    @(posedge clk); #1;
    d_ready0 = 1'b0; d_ready3 = 1'b0;
    @(negedge clk);
    chk("d_valid_after_hs", 32'(dv(w3)), 32'd0);
    chk("a_ready_after_hs", 32'(ar(w3)), 32'd1);
  endtask

  task automatic xact(input bit w3, input logic [2:0] op, input logic [2:0] sz,
                      input logic [1:0] src, input logic [31:0] addr,
                      input logic [3:0] msk, input logic [31:0] dat);
    send(w3, op, sz, src, addr, msk, dat);
    wait_d(w3);
    finish_d(w3);
  endtask

  task automatic check_resp(input string t, input logic [31:0] op, input logic [31:0] src,
                            input logic [31:0] sz, input logic [31:0] data,
                            input logic [31:0] err, input int lat);
    chk({t, ".lat"},    32'(r_lat), 32'(lat));
    chk({t, ".opcode"}, r_op, op);
    chk({t, ".source"}, r_src, src);
    chk({t, ".size"},   r_size, sz);
    chk({t, ".data"},   r_data, data);
    chk({t, ".error"},  r_err, err);
    chk({t, ".param"},  r_param, 32'd0);
    chk({t, ".sink"},   r_sink, 32'd0);
    chk({t, ".busy"},   32'(busy_ready), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst0_n = 1'b0; rst3_n = 1'b0;
    a_valid0 = 1'b0; a_valid3 = 1'b0; d_ready0 = 1'b0; d_ready3 = 1'b0;
    a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
    a_address = '0; a_mask = '0; a_data = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst.d_valid",  32'(d_valid0), 32'd0);
    chk("rst.d_data",   d_data0, 32'd0);
    chk("rst.d_opcode", 32'(d_opcode0), 32'd0);
    chk("rst.d_error",  32'(d_error0), 32'd0);
    chk("rst.d_source", 32'(d_source0), 32'd0);
    chk("rst3.d_valid", 32'(d_valid3), 32'd0);
    rst0_n = 1'b1; rst3_n = 1'b1;
    @(negedge clk);
    chk("rst.a_ready",  32'(a_ready0), 32'd1);
    chk("rst3.a_ready", 32'(a_ready3), 32'd1);

    xact(0, 3'd4, 3'd2, 2'd0, 32'h1000_0004, 4'hF, 32'h0);
    check_resp("get_after_reset", 1, 0, 2, 32'h0, 0, 0);

    xact(0, 3'd0, 3'd2, 2'd2, 32'h1000_0004, 4'hF, 32'hDEAD_BEEF);
    check_resp("put_full", 0, 2, 2, 32'h0, 0, 0);
    xact(0, 3'd4, 3'd2, 2'd1, 32'h1000_0004, 4'h0, 32'h0);
    check_resp("get_full", 1, 1, 2, 32'hDEAD_BEEF, 0, 0);

    xact(0, 3'd1, 3'd0, 2'd3, 32'h1000_0004, 4'h2, 32'h0000_5500);
    check_resp("put_partial", 0, 3, 0, 32'h0, 0, 0);
    xact(0, 3'd4, 3'd0, 2'd0, 32'h1000_0004, 4'h1, 32'h0);
    check_resp("get_partial", 1, 0, 0, 32'hDEAD_55EF, 0, 0);

    xact(0, 3'd4, 3'd2, 2'd1, 32'h1000_0040, 4'hF, 32'h0);
    check_resp("get_oor", 1, 1, 2, 32'h0, 1, 0);
    xact(0, 3'd4, 3'd2, 2'd2, 32'h1000_0002, 4'hF, 32'h0);
    check_resp("get_misaligned", 1, 2, 2, 32'h0, 1, 0);

    // Below-base put would alias onto the last word if the range check wrapped
    xact(0, 3'd0, 3'd2, 2'd0, 32'h0FFF_FFFC, 4'hF, 32'hCAFE_F00D);
    check_resp("put_below_base", 0, 0, 2, 32'h0, 1, 0);
    xact(0, 3'd4, 3'd2, 2'd0, 32'h1000_003C, 4'hF, 32'h0);
    check_resp("get_last_word_clean", 1, 0, 2, 32'h0, 0, 0);
    xact(0, 3'd0, 3'd2, 2'd1, 32'h1000_003C, 4'hF, 32'h0BAD_C0DE);
    check_resp("put_last_word", 0, 1, 2, 32'h0, 0, 0);
    xact(0, 3'd4, 3'd2, 2'd1, 32'h1000_003C, 4'hF, 32'h0);
    check_resp("get_last_word", 1, 1, 2, 32'h0BAD_C0DE, 0, 0);

    xact(0, 3'd2, 3'd2, 2'd3, 32'h1000_0004, 4'hF, 32'h1234_5678);
    check_resp("arith_op", 0, 3, 2, 32'h0, 1, 0);
    xact(0, 3'd4, 3'd2, 2'd0, 32'h1000_0004, 4'hF, 32'h0);
    check_resp("get_after_arith", 1, 0, 2, 32'hDEAD_55EF, 0, 0);

    xact(0, 3'd4, 3'd3, 2'd0, 32'h1000_0008, 4'hF, 32'h0);
    check_resp("get_size3", 1, 0, 3, 32'h0, 1, 0);
    xact(0, 3'd0, 3'd1, 2'd2, 32'h1000_0006, 4'hC, 32'hABCD_0000);
    check_resp("put_half", 0, 2, 1, 32'h0, 0, 0);
    xact(0, 3'd4, 3'd2, 2'd2, 32'h1000_0004, 4'hF, 32'h0);
    check_resp("get_after_half", 1, 2, 2, 32'hABCD_55EF, 0, 0);
    xact(0, 3'd0, 3'd1, 2'd1, 32'h1000_0005, 4'hF, 32'h1111_1111);
    check_resp("put_half_misaligned", 0, 1, 1, 32'h0, 1, 0);
    xact(0, 3'd4, 3'd2, 2'd2, 32'h1000_0004, 4'hF, 32'h0);
    check_resp("get_after_bad_half", 1, 2, 2, 32'hABCD_55EF, 0, 0);

    // Reset pulsed while a response is pending
    send(0, 3'd4, 3'd2, 2'd1, 32'h1000_0004, 4'hF, 32'h0);
    wait_d(0);
    check_resp("get_before_reset", 1, 1, 2, 32'hABCD_55EF, 0, 0);
    rst0_n = 1'b0;
    #1;
    chk("resp_reset.d_valid", 32'(d_valid0), 32'd0);
    chk("resp_reset.d_data",  d_data0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst0_n = 1'b1;
    chk("resp_reset.a_ready", 32'(a_ready0), 32'd1);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (d_valid0 !== 1'b0) cnt++;
    end
    chk("resp_reset.no_resp", 32'(cnt), 32'd0);
    xact(0, 3'd4, 3'd2, 2'd0, 32'h1000_0004, 4'hF, 32'h0);
    check_resp("get4_after_reset", 1, 0, 2, 32'h0, 0, 0);
    xact(0, 3'd4, 3'd2, 2'd0, 32'h1000_003C, 4'hF, 32'h0);
    check_resp("get3c_after_reset", 1, 0, 2, 32'h0, 0, 0);

    // Three wait states
    xact(1, 3'd0, 3'd2, 2'd1, 32'h1000_0008, 4'hF, 32'hA5A5_0F0F);
    check_resp("w3_put", 0, 1, 2, 32'h0, 0, 3);
    send(1, 3'd4, 3'd2, 2'd2, 32'h1000_0008, 4'hF, 32'h0);
    wait_d(1);
    check_resp("w3_get", 1, 2, 2, 32'hA5A5_0F0F, 0, 3);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (d_valid3 !== 1'b1 || a_ready3 !== 1'b0 || 32'(d_opcode3) !== r_op ||
          d_data3 !== r_data || 32'(d_source3) !== r_src || 32'(d_size3) !== r_size ||
          32'(d_error3) !== r_err) cnt++;
    end
    chk("w3_hold_stable", 32'(cnt), 32'd0);
    finish_d(1);

    // Reset pulsed while counting wait states
    send(1, 3'd4, 3'd2, 2'd0, 32'h1000_0008, 4'hF, 32'h0);
    @(negedge clk);
    rst3_n = 1'b0;
    @(negedge clk);
    rst3_n = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (d_valid3 !== 1'b0) cnt++;
    end
    chk("wait_reset.no_resp", 32'(cnt), 32'd0);
    chk("wait_reset.a_ready", 32'(a_ready3), 32'd1);
    xact(1, 3'd4, 3'd2, 2'd3, 32'h1000_0008, 4'hF, 32'h0);
    check_resp("w3_get_after_reset", 1, 3, 2, 32'h0, 0, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
